// File: rtl/func_gen_pkg.sv
// rtl/func_gen_pkg.sv - shared waveform codes, sequencer states and defaults
package func_gen_pkg;

   localparam logic [2:0] FUNC_RHOMBOID = 3'd0;
   localparam logic [2:0] FUNC_SINE     = 3'd1;
   localparam logic [2:0] FUNC_SQUARE   = 3'd2;
   localparam logic [2:0] FUNC_TRIANGLE = 3'd3;
   localparam logic [2:0] FUNC_SAWTOOTH = 3'd4;
   localparam logic [2:0] FUNC_MID      = 3'd5;

   localparam int DEF_DEPTH      = 8;
   localparam int DEF_AW         = 3;
   localparam int DEF_REP_W      = 8;
   localparam int DEF_PERIOD_LEN = 256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/seq_table.sv
// rtl/seq_table.sv - waveform/repeat table, one sync write port, one comb read port
module seq_table
   import func_gen_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW,
   parameter int REP_W = DEF_REP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [2:0]       i_wr_func,
   input  logic [REP_W-1:0] i_wr_reps,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [2:0]       o_rd_func,
   output logic [REP_W-1:0] o_rd_reps
);

   logic [2:0]       r_func [DEPTH];
   logic [REP_W-1:0] r_reps [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_func[i] <= FUNC_MID;
            r_reps[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_func[i_wr_addr] <= i_wr_func;
         r_reps[i_wr_addr] <= i_wr_reps;
      end
   end

   assign o_rd_func = r_func[i_rd_addr];
   assign o_rd_reps = r_reps[i_rd_addr];

endmodule

// File: rtl/func_sequencer.sv
// rtl/func_sequencer.sv - table-driven waveform scheduler for the function generator
module func_sequencer
   import func_gen_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AW         = DEF_AW,
   parameter int REP_W      = DEF_REP_W,
   parameter int PERIOD_LEN = DEF_PERIOD_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [AW-1:0]    wr_addr,
   input  logic [2:0]       wr_func,
   input  logic [REP_W-1:0] wr_reps,
   input  logic             start,
   input  logic             stop,
   input  logic [AW:0]      seq_len,
   input  logic             loop,
   output logic [2:0]       func,
   output logic             gen_rst,
   output logic             busy,
   output logic [AW-1:0]    step,
   output logic             step_pulse,
   output logic             done
);

   localparam int              PH_W      = (PERIOD_LEN > 1) ? $clog2(PERIOD_LEN) : 1;
   localparam logic [PH_W-1:0] L_PH_LAST = PH_W'(PERIOD_LEN - 1);
   localparam logic [AW:0]     L_DEPTH   = (AW + 1)'(DEPTH);

   seq_state_t       r_state;
   logic [2:0]       r_func;
   logic             r_gen_rst;
   logic             r_busy;
   logic [AW-1:0]    r_step;
   logic             r_step_pulse;
   logic             r_done;
   logic             r_wr_ready;
   logic [AW:0]      r_seq_len;
   logic             r_loop;
   logic [PH_W-1:0]  r_phase;
   logic [REP_W-1:0] r_rep;
   logic [REP_W-1:0] r_cur_reps;

   logic             w_wr_en;
   logic             w_len_ok;
   logic             w_last_step;
   logic [REP_W-1:0] w_eff_reps;
   logic             w_rep_last;
   logic [AW-1:0]    w_rd_addr;
   logic [2:0]       w_rd_func;
   logic [REP_W-1:0] w_rd_reps;

   assign w_wr_en     = wr_valid && r_wr_ready;
   assign w_len_ok    = (seq_len != '0) && (seq_len <= L_DEPTH);
   assign w_last_step = ({1'b0, r_step} == r_seq_len - 1'b1);
   assign w_eff_reps  = (r_cur_reps == '0) ? REP_W'(1) : r_cur_reps;
   assign w_rep_last  = (r_rep == w_eff_reps - 1'b1);

   // The read port always points at whichever entry gets loaded next: the
   // following entry while running mid-table, otherwise entry 0 (ARM or wrap).
   assign w_rd_addr = (r_state == ST_RUN && !w_last_step) ? r_step + 1'b1 : '0;

   seq_table #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .REP_W (REP_W)
   ) u_table (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_func (wr_func),
      .i_wr_reps (wr_reps),
      .i_rd_addr (w_rd_addr),
      .o_rd_func (w_rd_func),
      .o_rd_reps (w_rd_reps)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_func       <= FUNC_MID;
         r_gen_rst    <= 1'b0;
         r_busy       <= 1'b0;
         r_step       <= '0;
         r_step_pulse <= 1'b0;
         r_done       <= 1'b0;
         r_wr_ready   <= 1'b1;
         r_seq_len    <= '0;
         r_loop       <= 1'b0;
         r_phase      <= '0;
         r_rep        <= '0;
         r_cur_reps   <= '0;
      end else begin
         r_gen_rst    <= 1'b0;
         r_step_pulse <= 1'b0;
         r_done       <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && w_len_ok) begin
                  r_seq_len  <= seq_len;
                  r_loop     <= loop;
                  r_wr_ready <= 1'b0;
                  r_state    <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (stop) begin
                  r_state    <= ST_IDLE;
                  r_func     <= FUNC_MID;
                  r_busy     <= 1'b0;
                  r_step     <= '0;
                  r_wr_ready <= 1'b1;
               end else begin
                  r_gen_rst  <= 1'b1;
                  r_busy     <= 1'b1;
                  r_func     <= w_rd_func;
                  r_cur_reps <= w_rd_reps;
                  r_step     <= '0;
                  r_phase    <= '0;
                  r_rep      <= '0;
                  r_state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Abort takes priority over any entry boundary on the same edge.
               if (stop) begin
                  r_state    <= ST_IDLE;
                  r_func     <= FUNC_MID;
                  r_busy     <= 1'b0;
                  r_step     <= '0;
                  r_wr_ready <= 1'b1;
               end else if (r_phase != L_PH_LAST) begin
                  r_phase <= r_phase + 1'b1;
               end else if (!w_rep_last) begin
                  r_phase <= '0;
                  r_rep   <= r_rep + 1'b1;
               end else if (!w_last_step || r_loop) begin
                  r_step       <= w_rd_addr;
                  r_func       <= w_rd_func;
                  r_cur_reps   <= w_rd_reps;
                  r_step_pulse <= 1'b1;
                  r_phase      <= '0;
                  r_rep        <= '0;
               end else begin
                  r_done  <= 1'b1;
                  r_func  <= FUNC_MID;
                  r_busy  <= 1'b0;
                  r_step  <= '0;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_wr_ready <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign func       = r_func;
   assign gen_rst    = r_gen_rst;
   assign busy       = r_busy;
   assign step       = r_step;
   assign step_pulse = r_step_pulse;
   assign done       = r_done;
   assign wr_ready   = r_wr_ready;

endmodule

// File: doc/func_sequencer.md
Name: func_sequencer

Overview:
Programmable waveform scheduler that drives the 3-bit func select of the function generator. It holds a small table of {waveform code, repeat count} entries. It plays the table in order, switching waveform only on generator-period boundaries (PERIOD_LEN clocks). It pulses a one-cycle generator reset at sequence start so the sine oscillator restarts from a known phase, and supports one-shot or looped playback.

Parameters:
DEPTH, 8, number of table entries
AW, 3, table address width (log2 DEPTH)
REP_W, 8, repeat-count width (periods per entry)
PERIOD_LEN, 256, clocks per generator period (matches 8-bit phase counter)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
wr_valid  in  1  table write request
wr_ready  out  1  table write accepted when high with wr_valid (high only in IDLE)
wr_addr  in  AW  table entry index
wr_func  in  3  waveform code for entry
wr_reps  in  REP_W  periods to play entry (0 treated as 1)
start  in  1  start pulse, sampled in IDLE only
stop  in  1  abort pulse, sampled in ARM/RUN only
seq_len  in  AW+1  entries to play, legal 1..DEPTH, latched at start
loop  in  1  1 = wrap to entry 0 after last entry, latched at start
func  out  3  waveform select to generator (registered)
gen_rst  out  1  one-cycle generator reset pulse
busy  out  1  high in ARM and RUN
step  out  AW  index of entry currently playing
step_pulse  out  1  one-cycle pulse on each entry change
done  out  1  one-cycle pulse at normal end of one-shot sequence

Behaviour:
- Reset (async): state IDLE; func=3'b101 (mid-scale code); gen_rst=0, busy=0, step=0, step_pulse=0, done=0, wr_ready=1; table entries cleared to {3'b101, 0}; phase and rep counters 0.
- States: IDLE, ARM, RUN, DONE. All outputs registered.
- IDLE:
  - wr_valid&wr_ready writes table[wr_addr] on that edge.
  - start with seq_len in 1..DEPTH: latch seq_len/loop, go to ARM.
  - start with seq_len=0 or >DEPTH: ignored, no done.
  - start and wr_valid in the same cycle: the write completes and start is taken; entry 0 is read after the write.
- ARM (exactly 1 cycle):
  - gen_rst=1, func=table[0].func, step=0, busy=1, phase=0, rep=0.
  - Next state RUN.
- RUN:
  - phase counts 0..PERIOD_LEN-1 and wraps; rep increments on each wrap.
  - At phase==PERIOD_LEN-1 with rep==max(reps,1)-1, the entry ends.
    - If step < seq_len-1: step+1, func=table[step+1].func, step_pulse=1, phase=0, rep=0.
    - Last entry with loop=1: step=0, func=table[0].func, step_pulse=1. No gen_rst on wrap.
    - Last entry with loop=0: go DONE.
  - Each entry is active for exactly max(reps,1)*PERIOD_LEN RUN cycles.
- DONE (1 cycle): done=1, func=3'b101, busy=0, then IDLE.
- stop in ARM/RUN: next edge goes to IDLE with func=3'b101, busy=0, no done, no step_pulse. stop beats a coincident entry-end boundary.
- start in ARM/RUN/DONE: ignored. stop in IDLE: ignored.
- Writes are blocked while busy (wr_ready=0). Table contents persist across runs and stops; only rst clears them.
- Latency: start sampled at edge t → gen_rst/busy/func valid after edge t+1 → RUN from edge t+2.

Decomposition:
- Package func_gen_pkg:
  - Waveform codes: RHOMBOID=0, SINE=1, SQUARE=2, TRIANGLE=3, SAWTOOTH=4, MID=5.
  - State enum {IDLE, ARM, RUN, DONE}.
  - Default PERIOD_LEN.
- Sub-module seq_table: DEPTH x (3+REP_W) register file, one synchronous write port and one combinational read port, async clear on rst. The FSM and counters stay in func_sequencer.

Test Plan:
- Reset mid-RUN (rst asserted while step=2) → immediately func=5, busy=0, wr_ready=1, table read back as {5,0}.
- PERIOD_LEN=4; table {0:SQUARE,reps 2; 1:SINE,reps 1}; seq_len=2, loop=0; start → gen_rst high 1 cycle; func=2 for 8 RUN cycles; step_pulse then func=1 for 4 cycles; done pulse; func=5.
- Same table with loop=1 → func sequence 2,2(8 cycles),1(4 cycles) repeats ≥3 times; step_pulse every wrap; no gen_rst after ARM; done never asserts.
- reps=0 entry and start with seq_len=0 or 9 → reps=0 plays exactly PERIOD_LEN cycles; the illegal seq_len starts are ignored (busy stays 0).
- stop coincident with the last-entry boundary, loop=0 → IDLE, func=5, done=0.
- wr_valid while busy → wr_ready=0, table unchanged after the run.
- start+wr_valid(addr 0, SAWTOOTH) in the same IDLE cycle → ARM outputs func=4.
